// File: rtl/div_unit_if.sv
// Handshake and data bundle between the execute-stage control and the divider.
interface div_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic             sign;
  logic [WIDTH-1:0] in_0;
  logic [WIDTH-1:0] in_1;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             of;

  modport master (
    output start, sign, in_0, in_1, flush,
    input  busy, done, quot, rem, of
  );

  modport slave (
    input  start, sign, in_0, in_1, flush,
    output busy, done, quot, rem, of
  );
endinterface

// File: rtl/div_unit.sv
// Sequential restoring divider: signed/unsigned quotient and remainder in WIDTH
// steps, with single-cycle fast paths for divide-by-zero and signed MIN/-1.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset_,
  div_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_part;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvsr;
  logic             r_negQ;
  logic             r_negR;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quotOut;
  logic [WIDTH-1:0] r_remOut;
  logic             r_of;

  logic [WIDTH:0]   w_partSh;
  logic [WIDTH:0]   w_diff;
  logic             w_ok;
  logic [WIDTH-1:0] w_nextPart;
  logic [WIDTH-1:0] w_nextQuo;
  logic [WIDTH-1:0] w_absA;
  logic [WIDTH-1:0] w_absB;
  logic             w_divZero;
  logic             w_ovf;
  logic             w_last;

  // Partial remainder is always below the divisor, so a WIDTH+1 bit trial
  // subtraction never wraps and its MSB is a clean borrow flag.
  assign w_partSh   = {r_part, r_quo[WIDTH-1]};
  assign w_diff     = w_partSh - {1'b0, r_dvsr};
  assign w_ok       = ~w_diff[WIDTH];
  assign w_nextPart = w_ok ? w_diff[WIDTH-1:0] : w_partSh[WIDTH-1:0];
  assign w_nextQuo  = {r_quo[WIDTH-2:0], w_ok};

  assign w_absA    = (bus.sign && bus.in_0[WIDTH-1]) ? -bus.in_0 : bus.in_0;
  assign w_absB    = (bus.sign && bus.in_1[WIDTH-1]) ? -bus.in_1 : bus.in_1;
  assign w_divZero = (bus.in_1 == '0);
  assign w_ovf     = bus.sign && (bus.in_0 == MinVal) && (bus.in_1 == '1);
  assign w_last    = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!reset_) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_part    <= '0;
      r_quo     <= '0;
      r_dvsr    <= '0;
      r_negQ    <= 1'b0;
      r_negR    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_quotOut <= '0;
      r_remOut  <= '0;
      r_of      <= 1'b0;
    end else if (bus.flush) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
          if (bus.start) begin
            if (w_divZero) begin
              r_state   <= DONE;
              r_done    <= 1'b1;
              r_quotOut <= '1;
              r_remOut  <= bus.in_0;
              r_of      <= 1'b1;
            end else if (w_ovf) begin
              r_state   <= DONE;
              r_done    <= 1'b1;
              r_quotOut <= MinVal;
              r_remOut  <= '0;
              r_of      <= 1'b1;
            end else begin
              r_state <= CALC;
              r_busy  <= 1'b1;
              r_cnt   <= '0;
              r_part  <= '0;
              r_quo   <= w_absA;
              r_dvsr  <= w_absB;
              r_negQ  <= bus.sign & (bus.in_0[WIDTH-1] ^ bus.in_1[WIDTH-1]);
              r_negR  <= bus.sign & bus.in_0[WIDTH-1];
            end
          end
        end
        CALC: begin
          r_part <= w_nextPart;
          r_quo  <= w_nextQuo;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last) begin
            r_state   <= DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_quotOut <= r_negQ ? -w_nextQuo : w_nextQuo;
            r_remOut  <= r_negR ? -w_nextPart : w_nextPart;
            r_of      <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.quot = r_quotOut;
  assign bus.rem  = r_remOut;
  assign bus.of   = r_of;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: normal, signed, fast-path,
// back-to-back, flush and mid-operation reset scenarios.
module tb_div_unit;

  logic clk;
  logic reset_;
  int   checks;
  int   errors;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one operation and follow it until done, bounded to 100 cycles.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output int lat, output int busyCnt, output int overlap);
    bus.start = 1'b1;
    bus.sign  = s;
    bus.in_0  = a;
    bus.in_1  = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    busyCnt = 0;
    overlap = 0;
    while (!bus.done && lat < 100) begin
      if (bus.busy) busyCnt++;
      @(posedge clk); #1;
      lat++;
    end
    if (bus.busy && bus.done) overlap++;
  endtask

  task automatic test_reset();
    reset_    = 1'b0;
    bus.start = 1'b0;
    bus.sign  = 1'b0;
    bus.in_0  = '0;
    bus.in_1  = '0;
    bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.of, bus.quot, bus.rem} !== 67'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: got busy=%b done=%b of=%b quot=%h rem=%h required all 0",
               bus.busy, bus.done, bus.of, bus.quot, bus.rem);
    end
    reset_ = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned();
    int lat, bc, ov;
    issue(32'd100, 32'd7, 1'b0, lat, bc, ov);
    checks++;
    if (lat !== 33 || bc !== 32 || ov !== 0) begin
      errors++;
      $display("[TB] FAIL unsigned_timing: got lat=%0d busy=%0d overlap=%0d required 33/32/0", lat, bc, ov);
    end
    checks++;
    if (bus.quot !== 32'd14 || bus.rem !== 32'd2 || bus.of !== 1'b0) begin
      errors++;
      $display("[TB] FAIL unsigned_100_7: got q=%h r=%h of=%b required 0000000e/00000002/0", bus.quot, bus.rem, bus.of);
    end
  endtask

  task automatic test_signed();
    int lat, bc, ov;
    issue(32'hFFFFFFF9, 32'd2, 1'b1, lat, bc, ov);
    checks++;
    if (lat !== 33 || bus.quot !== 32'hFFFFFFFD || bus.rem !== 32'hFFFFFFFF || bus.of !== 1'b0) begin
      errors++;
      $display("[TB] FAIL signed_m7_2: got lat=%0d q=%h r=%h of=%b required 33/fffffffd/ffffffff/0",
               lat, bus.quot, bus.rem, bus.of);
    end
    issue(32'd7, 32'hFFFFFFFE, 1'b1, lat, bc, ov);
    checks++;
    if (bus.quot !== 32'hFFFFFFFD || bus.rem !== 32'd1 || bus.of !== 1'b0) begin
      errors++;
      $display("[TB] FAIL signed_7_m2: got q=%h r=%h of=%b required fffffffd/00000001/0", bus.quot, bus.rem, bus.of);
    end
    issue(32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, lat, bc, ov);
    checks++;
    if (bus.quot !== 32'd14 || bus.rem !== 32'hFFFFFFFE || bus.of !== 1'b0) begin
      errors++;
      $display("[TB] FAIL signed_m100_m7: got q=%h r=%h of=%b required 0000000e/fffffffe/0", bus.quot, bus.rem, bus.of);
    end
  endtask

  task automatic test_div_zero();
    int lat, bc, ov;
    for (int m = 0; m < 2; m++) begin
      issue(32'h12345678, 32'd0, m[0], lat, bc, ov);
      checks++;
      if (lat !== 1 || bc !== 0 || bus.quot !== 32'hFFFFFFFF || bus.rem !== 32'h12345678 || bus.of !== 1'b1) begin
        errors++;
        $display("[TB] FAIL div_zero_sign%0d: got lat=%0d busy=%0d q=%h r=%h of=%b required 1/0/ffffffff/12345678/1",
                 m, lat, bc, bus.quot, bus.rem, bus.of);
      end
    end
  endtask

  task automatic test_min_neg1();
    int lat, bc, ov;
    issue(32'h80000000, 32'hFFFFFFFF, 1'b1, lat, bc, ov);
    checks++;
    if (lat !== 1 || bc !== 0 || bus.quot !== 32'h80000000 || bus.rem !== 32'd0 || bus.of !== 1'b1) begin
      errors++;
      $display("[TB] FAIL signed_min_m1: got lat=%0d busy=%0d q=%h r=%h of=%b required 1/0/80000000/00000000/1",
               lat, bc, bus.quot, bus.rem, bus.of);
    end
    issue(32'h80000000, 32'hFFFFFFFF, 1'b0, lat, bc, ov);
    checks++;
    if (lat !== 33 || bus.quot !== 32'd0 || bus.rem !== 32'h80000000 || bus.of !== 1'b0) begin
      errors++;
      $display("[TB] FAIL unsigned_min_max: got lat=%0d q=%h r=%h of=%b required 33/00000000/80000000/0",
               lat, bus.quot, bus.rem, bus.of);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc, ov;
    issue(32'hFFFFFFFF, 32'd1, 1'b0, lat, bc, ov);
    checks++;
    if (lat !== 33 || bus.quot !== 32'hFFFFFFFF || bus.rem !== 32'd0) begin
      errors++;
      $display("[TB] FAIL max_div_1: got lat=%0d q=%h r=%h required 33/ffffffff/00000000", lat, bus.quot, bus.rem);
    end
    issue(32'd10, 32'd3, 1'b0, lat, bc, ov);
    checks++;
    if (lat !== 33 || bc !== 32 || bus.quot !== 32'd3 || bus.rem !== 32'd1) begin
      errors++;
      $display("[TB] FAIL back_to_back_10_3: got lat=%0d busy=%0d q=%h r=%h required 33/32/00000003/00000001",
               lat, bc, bus.quot, bus.rem);
    end
  endtask

  task automatic test_flush();
    int lat, bc, ov, doneSeen;
    bus.start = 1'b1;
    bus.sign  = 1'b0;
    bus.in_0  = 32'd1000;
    bus.in_1  = 32'd10;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quot !== 32'd3 || bus.rem !== 32'd1 || bus.of !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_abort: got busy=%b done=%b q=%h r=%h of=%b required 0/0/00000003/00000001/0",
               bus.busy, bus.done, bus.quot, bus.rem, bus.of);
    end
    doneSeen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) doneSeen++;
    end
    checks++;
    if (doneSeen !== 0) begin
      errors++;
      $display("[TB] FAIL flush_no_done: got %0d active cycles after flush required 0", doneSeen);
    end
    issue(32'd1000, 32'd10, 1'b0, lat, bc, ov);
    checks++;
    if (lat !== 33 || bus.quot !== 32'd100 || bus.rem !== 32'd0) begin
      errors++;
      $display("[TB] FAIL after_flush: got lat=%0d q=%h r=%h required 33/00000064/00000000", lat, bus.quot, bus.rem);
    end
  endtask

  task automatic test_flush_priority();
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.in_0  = 32'd20;
    bus.in_1  = 32'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quot !== 32'd100) begin
      errors++;
      $display("[TB] FAIL flush_over_start: got busy=%b done=%b q=%h required 0/0/00000064", bus.busy, bus.done, bus.quot);
    end
  endtask

  task automatic test_reset_midcalc();
    int lat, bc, ov;
    bus.start = 1'b1;
    bus.sign  = 1'b0;
    bus.in_0  = 32'd50;
    bus.in_1  = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    reset_ = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bus.busy, bus.done, bus.of, bus.quot, bus.rem} !== 67'd0) begin
      errors++;
      $display("[TB] FAIL reset_midcalc: got busy=%b done=%b of=%b q=%h r=%h required all 0",
               bus.busy, bus.done, bus.of, bus.quot, bus.rem);
    end
    reset_ = 1'b1;
    @(posedge clk); #1;
    issue(32'd9, 32'd4, 1'b0, lat, bc, ov);
    checks++;
    if (lat !== 33 || bus.quot !== 32'd2 || bus.rem !== 32'd1 || bus.of !== 1'b0) begin
      errors++;
      $display("[TB] FAIL after_reset: got lat=%0d q=%h r=%h of=%b required 33/00000002/00000001/0",
               lat, bus.quot, bus.rem, bus.of);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_min_neg1();
    test_back_to_back();
    test_flush();
    test_flush_priority();
    test_reset_midcalc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Sequential 32-cycle restoring divider for the execute stage, complementing the single-cycle combinational ALU. The ALU covers add, subtract, logic and shift in one cycle; `div_unit` provides signed and unsigned quotient and remainder over multiple cycles. It uses a start/done handshake and a busy indication that the pipeline control uses to stall the EX stage. Overflow reporting (divide-by-zero, signed MIN/−1) mirrors the ALU `of` semantics so the exception logic handles both units identically.

## Interface
- `WIDTH`, 32: operand/result width (word data bus width).
- `clk` in 1: single clock, all state updates on rising edge.
- `reset_` in 1: reset, synchronous, active-low.
- `start` in 1: request; sampled only in IDLE or DONE.
- `sign` in 1: 1 = signed (two's complement) division, 0 = unsigned; sampled with `start`.
- `in_0` in WIDTH: dividend; sampled with `start`.
- `in_1` in WIDTH: divisor; sampled with `start`.
- `flush` in 1: abort current operation (pipeline flush).
- `busy` out 1: high while in CALC.
- `done` out 1: high for exactly the one cycle the unit is in DONE.
- `quot` out WIDTH: registered quotient, held until next result.
- `rem` out WIDTH: registered remainder, held until next result.
- `of` out 1: registered overflow/exception flag, qualified by `done`.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE/DONE + `start`:
  - `in_1 == 0` → DONE.
  - `sign && in_0 == 2^(WIDTH-1) && in_1 == all-ones` → DONE.
  - Otherwise → CALC, with iteration counter = 0.
- IDLE/DONE without `start`: DONE → IDLE; IDLE holds.
- CALC: one restoring step per cycle.
  - Shift {partial remainder, dividend magnitude} left by 1.
  - Trial-subtract the divisor magnitude at WIDTH+1 bits.
  - If the difference is non-negative, keep it and set quotient LSB = 1; else restore.
  - After WIDTH steps (counter == WIDTH−1) → DONE, registering fixed-up results.
- Signed mode:
  - Operands are converted to magnitudes on capture.
  - Quotient is negated if the operand signs differ (truncation toward zero).
  - Remainder takes the sign of the dividend.
  - Invariant: `in_0 == quot*in_1 + rem` (mod 2^WIDTH).
- Divide by zero: `quot` = all-ones, `rem` = `in_0`, `of` = 1 (both modes).
- Signed MIN/−1: `quot` = 2^(WIDTH−1), `rem` = 0, `of` = 1.
- Normal completion: `of` = 0.
- `flush`, any state: → IDLE next cycle.
  - `done` is not asserted; `quot`/`rem`/`of` keep their previous values.
  - `flush` has priority over `start` in the same cycle.
- Reset (`reset_` low at an edge, including mid-CALC): → IDLE; `busy`=0, `done`=0, `quot`=0, `rem`=0, `of`=0, counter=0. Reset has priority over `flush` and `start`.
- `start` while in CALC is ignored. The control logic must not issue it, because `busy` stalls EX.

## Timing
- `start` is sampled at edge k.
- Normal path:
  - `busy` = 1 in cycles k+1 … k+WIDTH.
  - `done` = 1 in cycle k+WIDTH+1 (33 cycles after `start` for WIDTH=32).
  - `quot`/`rem`/`of` are valid in that same cycle.
- Fast paths (divide-by-zero, MIN/−1): `done` = 1 in cycle k+1; `busy` never asserts.
- Back-to-back: `start` in the DONE cycle is accepted, giving one result every WIDTH+1 cycles.
- `busy` and `done` are never high together.
- Outputs are purely registered; there are no combinational paths from inputs to outputs.

## Test plan
- Unsigned, `in_0`=100, `in_1`=7, `sign`=0 → `busy` for 32 cycles; `done` at k+33 with `quot`=14, `rem`=2, `of`=0.
- Signed, `in_0`=0xFFFFFFF9 (−7), `in_1`=2 → `quot`=0xFFFFFFFD (−3), `rem`=0xFFFFFFFF (−1), `of`=0.
- Signed and unsigned with `in_1`=0, `in_0`=0x12345678 → `done` at k+1, `quot`=0xFFFFFFFF, `rem`=0x12345678, `of`=1. Then signed 0x80000000 / 0xFFFFFFFF → `quot`=0x80000000, `rem`=0, `of`=1. Unsigned of the same operands → 33-cycle path, `quot`=0, `rem`=0x80000000, `of`=0.
- Unsigned 0xFFFFFFFF / 1 → `quot`=0xFFFFFFFF, `rem`=0. Immediately after, `start` in the DONE cycle with 10/3 → second `done` 33 cycles later with `quot`=3, `rem`=1.
- `flush` at k+10 of a running divide → IDLE at k+11, no `done`, previous `quot`/`rem` unchanged. Separately, `reset_` low at k+5 → all outputs 0 next cycle. A new `start` after either completes normally.
